// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_engine
// Description : Simple DMA that copies len words from src to dst over a single
//               memory port, alternating one read cycle with one write cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] src,
    input  logic [N-1:0] dst,
    input  logic [N-1:0] len,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_in,
    output logic         mem_write_en,
    input  logic [N-1:0] mem_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_src;
    logic [N-1:0] r_dst;
    logic [N-1:0] r_remaining;
    logic [N-1:0] r_buffer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_buffer    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src       <= src;
                        r_dst       <= dst;
                        r_remaining <= len;
                    end
                end
                S_READ: begin
                    r_buffer <= mem_out;
                    r_src    <= r_src + c_one;
                end
                S_WRITE: begin
                    r_dst       <= r_dst + c_one;
                    r_remaining <= r_remaining - c_one;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only from registered state, so an async reset drops
    // mem_write_en immediately without waiting for a clock edge.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mem_address  = '0;
        mem_write_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy         = 1'b1;
                mem_address  = r_src;
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                mem_address  = r_dst;
                mem_write_en = 1'b1;
                w_next_state = (r_remaining == c_one) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign mem_in = r_buffer;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Self-checking bench for mem_copy_engine with a 1k x 16 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src, dst, len;
    logic        busy, done, mem_write_en;
    logic [15:0] mem_address, mem_in, mem_out;

    logic [15:0] mem [0:1023];
    logic        tb_clr, tb_we;
    logic [9:0]  tb_addr;
    logic [15:0] tb_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.N(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_write_en(mem_write_en),
        .mem_out     (mem_out)
    );

    // Memory model: 1024 words, aliased on the low 10 address bits, address 0 reads 0.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_write_en) begin
            mem[mem_address[9:0]] <= mem_in;
        end
    end
    assign mem_out = (mem_address[9:0] == 10'd0) ? 16'h0 : mem[mem_address[9:0]];

    typedef struct {
        logic [15:0]      src;
        logic [15:0]      dst;
        logic [15:0]      len;
        logic [3:0][15:0] pre;   // preloaded at src+0..3, element 0 in low bits
        logic [3:0][15:0] exp;   // expected at dst+0..len-1
        logic [15:0]      after; // expected word just past the destination block
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_clear();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); tb_we = 1'b1; tb_addr = a[9:0]; tb_data = d;
        @(negedge clk); tb_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        @(negedge clk); src = s; dst = d; len = l; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Starts a transfer and samples every negedge until done; returns counts.
    task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       output int busy_cnt, output int we_cnt, output bit done_seen,
                       output bit done_after);
        pulse_start(s, d, l);
        busy_cnt  = 0;
        we_cnt    = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (mem_write_en) we_cnt++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    initial begin
        int  bc, wc, dcnt;
        bit  ds, da;
        logic [15:0] a;

        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        tb_clr = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;

        vecs[0] = '{16'd100, 16'd200, 16'd4,
                    {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                    {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 16'h0000};
        vecs[1] = '{16'd10, 16'd20, 16'd0,
                    {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    {16'h0, 16'h0, 16'h0, 16'h0}, 16'h0000};
        vecs[2] = '{16'd0, 16'd50, 16'd2,
                    {16'h0000, 16'h0000, 16'h00AB, 16'hFFFF},
                    {16'h0000, 16'h0000, 16'h00AB, 16'h0000}, 16'h0000};
        vecs[3] = '{16'd10, 16'd11, 16'd2,
                    {16'h0000, 16'h0003, 16'h0002, 16'h0001},
                    {16'h0000, 16'h0000, 16'h0001, 16'h0001}, 16'h0000};
        vecs[4] = '{16'hFFFF, 16'h0300, 16'd2,
                    {16'h0000, 16'h0000, 16'h5555, 16'hAAAA},
                    {16'h0000, 16'h0000, 16'h0000, 16'hAAAA}, 16'h0000};
        vecs[5] = '{16'h0200, 16'hFFFF, 16'd2,
                    {16'h0000, 16'h0000, 16'h0456, 16'h0123},
                    {16'h0000, 16'h0000, 16'h0456, 16'h0123}, 16'h0000};

        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset we", {31'd0, mem_write_en}, 32'd0);
        chk("reset addr", {16'd0, mem_address}, 32'd0);
        chk("reset mem_in", {16'd0, mem_in}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            mem_clear();
            for (int k = 0; k < 4; k++) begin
                a = vecs[i].src + 16'(k);
                poke(a, vecs[i].pre[k]);
            end
            run(vecs[i].src, vecs[i].dst, vecs[i].len, bc, wc, ds, da);
            chk($sformatf("v%0d done seen", i), {31'd0, ds}, 32'd1);
            chk($sformatf("v%0d busy cycles", i), bc, 2 * int'(vecs[i].len));
            chk($sformatf("v%0d write cycles", i), wc, int'(vecs[i].len));
            chk($sformatf("v%0d done width", i), {31'd0, da}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                if (k < int'(vecs[i].len)) begin
                    a = vecs[i].dst + 16'(k);
                    chk($sformatf("v%0d word%0d", i, k), {16'd0, mem[a[9:0]]}, {16'd0, vecs[i].exp[k]});
                end
            end
            a = vecs[i].dst + vecs[i].len;
            chk($sformatf("v%0d past end", i), {16'd0, mem[a[9:0]]}, {16'd0, vecs[i].after});
        end
        chk("basic src kept", {16'd0, mem[103]}, 32'h0000);

        // Start while busy: the second request must be dropped.
        mem_clear();
        poke(16'd100, 16'h1111); poke(16'd101, 16'h2222);
        poke(16'd102, 16'h3333); poke(16'd103, 16'h4444);
        poke(16'd10, 16'h7777);
        pulse_start(16'd100, 16'd300, 16'd4);
        @(negedge clk); @(negedge clk);
        src = 16'd10; dst = 16'd400; len = 16'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("busy start done count", dcnt, 1);
        chk("busy start w0", {16'd0, mem[300]}, 32'h1111);
        chk("busy start w3", {16'd0, mem[303]}, 32'h4444);
        chk("busy start dropped", {16'd0, mem[400]}, 32'h0000);

        // Reset during the second WRITE cycle.
        mem_clear();
        poke(16'd100, 16'h1111); poke(16'd101, 16'h2222);
        poke(16'd102, 16'h3333); poke(16'd103, 16'h4444);
        pulse_start(16'd100, 16'd500, 16'd4);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre-reset we", {31'd0, mem_write_en}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async we drop", {31'd0, mem_write_en}, 32'd0);
        chk("async busy drop", {31'd0, busy}, 32'd0);
        chk("async addr", {16'd0, mem_address}, 32'd0);
        @(negedge clk); reset = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("aborted idle", dcnt, 0);
        chk("aborted word0", {16'd0, mem[500]}, 32'h1111);
        chk("aborted word1", {16'd0, mem[501]}, 32'h0000);
        run(16'd102, 16'd600, 16'd1, bc, wc, ds, da);
        chk("post-reset done", {31'd0, ds}, 32'd1);
        chk("post-reset busy", bc, 2);
        chk("post-reset data", {16'd0, mem[600]}, 32'h3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
